// File: rtl/rd_pending_scoreboard.sv
// Destination-register scoreboard for a dual-issue pipeline: counts in-flight writers per
// architectural register and answers decode-stage busy, load-use and intra-pair queries.
module rd_pending_scoreboard #(
    parameter int NREG  = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          iss_vld_0,
    input  logic          iss_vld_1,
    input  logic [AW-1:0] iss_rd_0,
    input  logic [AW-1:0] iss_rd_1,
    input  logic          iss_wen_0,
    input  logic          iss_wen_1,
    input  logic          iss_ld_0,
    input  logic          iss_ld_1,
    input  logic          kill_vld_0,
    input  logic          kill_vld_1,
    input  logic [AW-1:0] kill_rd_0,
    input  logic [AW-1:0] kill_rd_1,
    input  logic          wb_vld_0,
    input  logic          wb_vld_1,
    input  logic [AW-1:0] wb_rd_0,
    input  logic [AW-1:0] wb_rd_1,
    input  logic [AW-1:0] q_rs1_0,
    input  logic [AW-1:0] q_rs2_0,
    input  logic [AW-1:0] q_rs1_1,
    input  logic [AW-1:0] q_rs2_1,
    input  logic [AW-1:0] q_rd_0,
    input  logic          q_ld_0,
    output logic [3:0]    busy,
    output logic          ld_use_stall,
    output logic          pair_split,
    output logic          sb_err
);

    // Two guard bits let the sum of +2 increments and -4 decrements be range-checked before clamping.
    localparam int SW = CNT_W + 2;
    localparam logic [SW-1:0] CNT_MAX = SW'((1 << CNT_W) - 1);

    function automatic logic [SW-1:0] hit(input logic vld, input logic [AW-1:0] a, input logic [AW-1:0] r);
        hit = (vld && (a == r)) ? SW'(1) : SW'(0);
    endfunction

    logic [CNT_W-1:0] r_cnt [NREG];
    logic [CNT_W-1:0] w_cnt_nxt [NREG];
    logic [NREG-1:0]  r_ld_young;
    logic [NREG-1:0]  w_ld_young_nxt;
    logic             r_sb_err;
    logic             w_err_evt;
    logic [AW-1:0]    w_ra;
    logic [SW-1:0]    w_inc;
    logic [SW-1:0]    w_dec;
    logic [SW-1:0]    w_sum;

    // Next-state counters and load-age bits; entry 0 stays zero so x0 is never tracked.
    always_comb begin
        w_ld_young_nxt = '0;
        w_err_evt      = 1'b0;
        w_ra           = '0;
        w_inc          = '0;
        w_dec          = '0;
        w_sum          = '0;
        for (int r = 0; r < NREG; r++) begin
            w_cnt_nxt[r] = '0;
        end
        for (int r = 1; r < NREG; r++) begin
            w_ra  = AW'(r);
            w_inc = hit(iss_vld_0 && iss_wen_0, iss_rd_0, w_ra) + hit(iss_vld_1 && iss_wen_1, iss_rd_1, w_ra);
            w_dec = hit(kill_vld_0, kill_rd_0, w_ra) + hit(kill_vld_1, kill_rd_1, w_ra)
                  + hit(wb_vld_0, wb_rd_0, w_ra) + hit(wb_vld_1, wb_rd_1, w_ra);
            w_sum = {2'b00, r_cnt[r]} + w_inc - w_dec;
            if (w_sum[SW-1]) begin
                w_cnt_nxt[r] = '0;
                w_err_evt    = 1'b1;
            end else if (w_sum > CNT_MAX) begin
                w_cnt_nxt[r] = CNT_MAX[CNT_W-1:0];
                w_err_evt    = 1'b1;
            end else begin
                w_cnt_nxt[r] = w_sum[CNT_W-1:0];
            end
            w_ld_young_nxt[r] = (iss_vld_0 && iss_wen_0 && iss_ld_0 && (iss_rd_0 == w_ra))
                             || (iss_vld_1 && iss_wen_1 && iss_ld_1 && (iss_rd_1 == w_ra));
        end
    end

    // State register with synchronous active-low reset; error flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r] <= '0;
            end
            r_ld_young <= '0;
            r_sb_err   <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_ld_young <= w_ld_young_nxt;
            r_sb_err   <= r_sb_err | w_err_evt;
        end
    end

    assign busy[0] = (q_rs1_0 != '0) && (r_cnt[q_rs1_0] != '0);
    assign busy[1] = (q_rs2_0 != '0) && (r_cnt[q_rs2_0] != '0);
    assign busy[2] = (q_rs1_1 != '0) && (r_cnt[q_rs1_1] != '0);
    assign busy[3] = (q_rs2_1 != '0) && (r_cnt[q_rs2_1] != '0);

    assign ld_use_stall = ((q_rs1_0 != '0) && r_ld_young[q_rs1_0])
                       || ((q_rs2_0 != '0) && r_ld_young[q_rs2_0])
                       || ((q_rs1_1 != '0) && r_ld_young[q_rs1_1])
                       || ((q_rs2_1 != '0) && r_ld_young[q_rs2_1]);

    assign pair_split = q_ld_0 && (q_rd_0 != '0) && ((q_rd_0 == q_rs1_1) || (q_rd_0 == q_rs2_1));

    assign sb_err = r_sb_err;

endmodule
